toggle_rx: RTL and testbench



---
 rtl/toggle_rx_pkg.sv | 18 +
 rtl/toggle_rx_if.sv | 9 +
 rtl/toggle_rx_dec.sv | 25 ++
 rtl/toggle_rx.sv | 121 ++++++++++++
 tb/tb_toggle_rx.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/toggle_rx_pkg.sv
// rtl/toggle_rx_pkg.sv - shared types and constants for the toggle-stream receiver
package toggle_rx_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam logic [7:0] SYNC_WORD_DEF = 8'hA5;
  localparam int         BIT_CNT_W     = 3;

  // Even parity over a data byte plus its parity bit: 1 when the 9-bit total is even.
  function automatic logic parity_ok(input logic [7:0] d, input logic p);
    return ~(^{d, p});
  endfunction

endpackage

// File: rtl/toggle_rx_if.sv
// rtl/toggle_rx_if.sv - byte output handshake between the receiver and its consumer
interface toggle_rx_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/toggle_rx_dec.sv
// rtl/toggle_rx_dec.sv - recovers T bits from sampled Q of a T flip-flop line
module toggle_dec (
  input  logic clk,
  input  logic rst_n,
  input  logic q_in,
  input  logic bit_en,
  output logic t,
  output logic bit_vld
);

  logic q_prev;

  // Remember the last sampled line level; only strobed samples count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_prev <= 1'b0;
    end else if (bit_en) begin
      q_prev <= q_in;
    end
  end

  assign t       = q_in ^ q_prev;
  assign bit_vld = bit_en;

endmodule

// File: rtl/toggle_rx.sv
// rtl/toggle_rx.sv - sync hunt, frame assembly and byte handshake (TOGGLE_RX_PARITY_EN adds parity bit)
module toggle_rx
  import toggle_rx_pkg::*;
#(
  parameter logic [7:0] SYNC_WORD   = SYNC_WORD_DEF,
  parameter int         FRAME_BYTES = 4
) (
  input  logic        clk,
  input  logic        Rst_n,
  input  logic        Q_in,
  input  logic        bit_en,
  toggle_rx_if.master out_if,
  output logic        sync_lock,
  output logic        err
);

  localparam logic [7:0] LAST_BYTE = 8'(FRAME_BYTES - 1);

  logic                 t;
  logic                 bit_vld;
  state_t               state;
  logic [7:0]           shift;
  logic [7:0]           shift_next;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [7:0]           byte_cnt;
  logic [7:0]           out_data_q;
  logic                 out_valid_q;
  logic                 par_ok;
  logic                 commit;
  logic [7:0]           commit_byte;

  toggle_dec u_dec (
    .clk    (clk),
    .rst_n  (Rst_n),
    .q_in   (Q_in),
    .bit_en (bit_en),
    .t      (t),
    .bit_vld(bit_vld)
  );

  // Decide whether this strobe completes a byte and which value it carries.
  always_comb begin
    shift_next = {shift[6:0], t};
`ifdef TOGGLE_RX_PARITY_EN
    par_ok      = parity_ok(shift, t);
    commit      = bit_vld && (state == PARITY) && par_ok;
    commit_byte = shift;
`else
    par_ok      = 1'b1;
    commit      = bit_vld && (state == DATA) && (bit_cnt == 3'd7);
    commit_byte = shift_next;
`endif
  end

  // Frame FSM plus output holding register; commit effects override the per-state updates.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state       <= HUNT;
      shift       <= 8'h00;
      bit_cnt     <= '0;
      byte_cnt    <= 8'h00;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      err         <= 1'b0;
    end else begin
      err <= 1'b0;
      if (out_valid_q && out_if.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (bit_vld) begin
        case (state)
          HUNT: begin
            shift <= shift_next;
            if (shift_next == SYNC_WORD) begin
              state    <= DATA;
              bit_cnt  <= '0;
              byte_cnt <= 8'h00;
            end
          end
          DATA: begin
            shift   <= shift_next;
            bit_cnt <= bit_cnt + 1'b1;
`ifdef TOGGLE_RX_PARITY_EN
            if (bit_cnt == 3'd7) begin
              state <= PARITY;
            end
`endif
          end
          PARITY: begin
            if (par_ok) begin
              state <= DATA;
            end else begin
              err   <= 1'b1;
              state <= HUNT;
              shift <= 8'h00;
            end
          end
          default: state <= HUNT;
        endcase
      end
      if (commit) begin
        if (out_valid_q && !out_if.out_ready) begin
          err <= 1'b1;
        end else begin
          out_data_q  <= commit_byte;
          out_valid_q <= 1'b1;
        end
        byte_cnt <= byte_cnt + 8'd1;
        if (byte_cnt == LAST_BYTE) begin
          state <= HUNT;
          shift <= 8'h00;
        end
      end
    end
  end

  assign out_if.out_data  = out_data_q;
  assign out_if.out_valid = out_valid_q;
  assign sync_lock        = (state != HUNT);

endmodule

// File: tb/tb_toggle_rx.sv
// tb/tb_toggle_rx.sv - self-checking bench for toggle_rx
module tb_toggle_rx;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         FB   = 4;
`ifdef TOGGLE_RX_PARITY_EN
  localparam int         BPB  = 9;
`else
  localparam int         BPB  = 8;
`endif

  logic clk = 1'b0;
  logic Rst_n;
  logic Q_in;
  logic bit_en;
  logic sync_lock;
  logic err;
  logic q_line;

  toggle_rx_if bus ();

  toggle_rx #(.SYNC_WORD(SYNC), .FRAME_BYTES(FB)) dut (
    .clk      (clk),
    .Rst_n    (Rst_n),
    .Q_in     (Q_in),
    .bit_en   (bit_en),
    .out_if   (bus),
    .sync_lock(sync_lock),
    .err      (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: bit-history window while hunting, bit accumulator while locked
  int         m_hist;
  bit         m_lock;
  int         m_nbits;
  int         m_acc;
  int         m_nbytes;
  bit         m_valid;
  logic [7:0] m_data;
  bit         m_err;
  bit         m_loaded;

  typedef struct {
    logic [7:0] data;
    bit         rdy_bits;
    bit         rdy_last;
    logic [7:0] e_data;
    bit         e_valid;
    bit         e_err;
    bit         e_lock;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hist = 0; m_lock = 0; m_nbits = 0; m_acc = 0; m_nbytes = 0;
    m_valid = 0; m_data = 8'h00; m_err = 0;
  endtask

  task automatic model_commit(input int b, input bit r);
    if (!m_valid || r) begin
      m_data   = 8'(b);
      m_loaded = 1;
    end else begin
      m_err = 1;
    end
    m_nbytes++;
    if (m_nbytes == FB) begin
      m_lock = 0;
      m_hist = 0;
    end
  endtask

  task automatic model_step(input bit en, input bit t, input bit r);
    m_err    = 0;
    m_loaded = 0;
    if (en) begin
      if (!m_lock) begin
        m_hist = ((m_hist << 1) | int'(t)) & 255;
        if (m_hist == int'(SYNC)) begin
          m_lock = 1; m_nbits = 0; m_acc = 0; m_nbytes = 0;
        end
      end else begin
        m_acc = (m_acc << 1) | int'(t);
        m_nbits++;
        if (m_nbits == BPB) begin
`ifdef TOGGLE_RX_PARITY_EN
          if ($countones(m_acc) % 2 != 0) begin
            m_err = 1; m_lock = 0; m_hist = 0;
          end else begin
            model_commit(m_acc >> 1, r);
          end
`else
          model_commit(m_acc, r);
`endif
          m_nbits = 0;
          m_acc   = 0;
        end
      end
    end
    m_valid = m_loaded ? 1'b1 : (m_valid && !r);
  endtask

  task automatic step(input bit en, input bit t, input bit rdy);
    @(negedge clk);
    bit_en        = en;
    bus.out_ready = rdy;
    if (en) begin
      q_line = q_line ^ t;
      Q_in   = q_line;
    end else begin
      Q_in = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    #1;
    model_step(en, t, rdy);
    chk("out_valid", 8'(bus.out_valid), 8'(m_valid));
    chk("out_data", bus.out_data, m_data);
    chk("sync_lock", 8'(sync_lock), 8'(m_lock));
    chk("err", 8'(err), 8'(m_err));
  endtask

  task automatic send_sync(input bit rdy);
    for (int i = 7; i >= 0; i--) step(1'b1, SYNC[i], rdy);
  endtask

  // data bits, then the parity bit when enabled; rdy_last applies to the byte's final strobe
  task automatic send_byte(input logic [7:0] d, input bit rdy_bits, input bit rdy_last, input bit bad_par);
    for (int i = 7; i >= 0; i--) step(1'b1, d[i], (i == 0 && BPB == 8) ? rdy_last : rdy_bits);
    if (BPB == 9) step(1'b1, (^d) ^ bad_par, rdy_last);
  endtask

  initial begin
    vt[0]  = '{8'h3C, 1, 1, 8'h3C, 1, 0, 1};
    vt[1]  = '{8'hFF, 1, 1, 8'hFF, 1, 0, 1};
    vt[2]  = '{8'h00, 1, 1, 8'h00, 1, 0, 1};
    vt[3]  = '{8'h81, 1, 1, 8'h81, 1, 0, 0};
    vt[4]  = '{8'h3C, 0, 0, 8'h3C, 1, 0, 1};
    vt[5]  = '{8'hFF, 0, 0, 8'h3C, 1, 1, 1};
    vt[6]  = '{8'h00, 0, 0, 8'h3C, 1, 1, 1};
    vt[7]  = '{8'h81, 0, 0, 8'h3C, 1, 1, 0};
    vt[8]  = '{8'h3C, 0, 0, 8'h3C, 1, 0, 1};
    vt[9]  = '{8'hFF, 0, 1, 8'hFF, 1, 0, 1};
    vt[10] = '{8'h00, 0, 1, 8'h00, 1, 0, 1};
    vt[11] = '{8'h81, 0, 1, 8'h81, 1, 0, 0};

    Rst_n = 1'b0; Q_in = 1'b0; bit_en = 1'b0; bus.out_ready = 1'b0; q_line = 1'b0;
    model_reset();
    #2;
    chk("rst_valid", 8'(bus.out_valid), 8'h00);
    chk("rst_data", bus.out_data, 8'h00);
    chk("rst_lock", 8'(sync_lock), 8'h00);
    chk("rst_err", 8'(err), 8'h00);
    @(negedge clk);
    Rst_n = 1'b1;

    // table: three frames covering free-flowing, full back-pressure and same-edge accept
    for (int i = 0; i < 12; i++) begin
      if (i % 4 == 0) begin
        send_sync(1'b1);
        chk("lock_after_sync", 8'(sync_lock), 8'h01);
      end
      send_byte(vt[i].data, vt[i].rdy_bits, vt[i].rdy_last, 1'b0);
      chk("tbl_data", bus.out_data, vt[i].e_data);
      chk("tbl_valid", 8'(bus.out_valid), 8'(vt[i].e_valid));
      chk("tbl_err", 8'(err), 8'(vt[i].e_err));
      chk("tbl_lock", 8'(sync_lock), 8'(vt[i].e_lock));
      if (i == 7) begin
        step(1'b0, 1'b0, 1'b0);
        chk("hold_valid", 8'(bus.out_valid), 8'h01);
        chk("hold_data", bus.out_data, 8'h3C);
        step(1'b0, 1'b0, 1'b1);
        chk("drain_valid", 8'(bus.out_valid), 8'h00);
      end
    end

    // false sync: A5 first lines up on the 12th bit
    begin
      logic [11:0] fs;
      fs = 12'b1110_1010_0101;
      for (int i = 11; i >= 0; i--) begin
        step(1'b1, fs[i], 1'b1);
        chk("false_sync_lock", 8'(sync_lock), (i == 0) ? 8'h01 : 8'h00);
      end
      send_byte(8'h5A, 1, 1, 1'b0);
      chk("fs_byte", bus.out_data, 8'h5A);
      for (int k = 0; k < 3; k++) send_byte(8'(k + 1), 1, 1, 1'b0);
      chk("fs_unlock", 8'(sync_lock), 8'h00);
    end

`ifdef TOGGLE_RX_PARITY_EN
    send_sync(1'b1);
    send_byte(8'h3C, 1, 1, 1'b1);
    chk("par_err", 8'(err), 8'h01);
    chk("par_lock", 8'(sync_lock), 8'h00);
    step(1'b0, 1'b0, 1'b1);
    chk("par_novalid", 8'(bus.out_valid), 8'h00);
    send_sync(1'b1);
    send_byte(8'h3C, 1, 1, 1'b0);
    chk("par_ok_data", bus.out_data, 8'h3C);
    chk("par_ok_valid", 8'(bus.out_valid), 8'h01);
    for (int k = 0; k < 3; k++) send_byte(8'h11, 1, 1, 1'b0);
`endif

    // randomized traffic with sync words injected so frames actually occur
    for (int k = 0; k < 25; k++) begin
      for (int i = 7; i >= 0; i--) step(1'b1, SYNC[i], 1'($urandom_range(0, 1)));
      for (int j = 0; j < 50; j++)
        step(($urandom % 4) != 0, 1'($urandom_range(0, 1)), ($urandom % 3) != 0);
    end

    // asynchronous reset mid-frame with a byte still held
    send_sync(1'b0);
    send_byte(8'hC3, 0, 0, 1'b0);
    send_sync(1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("pre_rst_valid", 8'(bus.out_valid), 8'h01);
    chk("pre_rst_lock", 8'(sync_lock), 8'h01);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("arst_valid", 8'(bus.out_valid), 8'h00);
    chk("arst_data", bus.out_data, 8'h00);
    chk("arst_lock", 8'(sync_lock), 8'h00);
    chk("arst_err", 8'(err), 8'h00);
    @(negedge clk);
    @(negedge clk);
    Rst_n = 1'b1; q_line = 1'b0; Q_in = 1'b0;
    model_reset();
    send_sync(1'b1);
    send_byte(8'h96, 1, 1, 1'b0);
    chk("post_rst_data", bus.out_data, 8'h96);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
